regs_dump: RTL and testbench

Debug read-out engine for the 32×32 register file. On a `start` pulse it walks a contiguous (wrapping) range of register indices. For each index it drives the register file's read-address port, captures the read data, and presents each word with its index on a valid/ready stream. It sits beside the datapath as the reading end of the register file; the write side remains the CPU's `we`/`rw`/`din` port.

---
 rtl/regs_pkg.sv | 15 +
 rtl/regs_dump.sv | 92 +++++++++
 tb/tb_regs_dump.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/regs_pkg.sv
// Shared constants and FSM state type for the register-file dump engine.
package regs_pkg;

    localparam int NREG = 32;   // number of registers, power of two
    localparam int AW   = 5;    // index width, log2(NREG)
    localparam int DW   = 32;   // data width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regs_dump.sv
// Debug read-out engine: walks a contiguous, wrapping range of register
// indices. For each index it reads the register file and presents
// {index, data} on a valid/ready stream. It finishes with a one-cycle done.
module regs_dump
    import regs_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] first_idx,
    input  logic [AW-1:0] last_idx,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout_data,
    output logic [AW-1:0] dout_idx,
    output logic          busy,
    output logic          done
);

    dump_state_t   state_r;
    logic [AW-1:0] cur_idx_r;   // index being read or presented
    logic [AW-1:0] end_idx_r;   // inclusive last index of this dump

    // The read address is the current-index register itself.
    // It stays stable in every state and is 0 after reset.
    assign rd_addr = cur_idx_r;

    // Dump sequencer: one READ/SEND pair per word.
    // The index wraps by natural AW-bit overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cur_idx_r  <= '0;
            end_idx_r  <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cur_idx_r <= first_idx;
                        end_idx_r <= last_idx;
                        busy      <= 1'b1;
                        state_r   <= READ;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                READ: begin
                    // Capture at this edge. Later register writes do not affect the word.
                    dout_data  <= rd_data;
                    dout_idx   <= cur_idx_r;
                    dout_valid <= 1'b1;
                    state_r    <= SEND;
                end
                SEND: begin
                    if (dout_valid && dout_ready) begin
                        dout_valid <= 1'b0;
                        if (cur_idx_r == end_idx_r) begin
                            done    <= 1'b1;
                            state_r <= FIN;
                        end else begin
                            cur_idx_r <= cur_idx_r + AW'(1);
                            state_r   <= READ;
                        end
                    end else begin
                        // Backpressure: hold the presented word unchanged.
                        state_r <= SEND;
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    dout_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regs_dump.sv
// Directed self-checking bench for regs_dump with a behavioural register file.
module tb_regs_dump;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;
    logic [4:0]  dout_idx;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    int          n_vec;
    int          n_err;

    assign rd_data = regs[rd_addr];

    regs_dump dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_idx  (first_idx),
        .last_idx   (last_idx),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_idx   (dout_idx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one dump of nexp words (count computed by hand at the call site).
    // Optionally stall word number stall_word for stall_len cycles.
    // The register being presented is rewritten during the stall.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int nexp,
                            input int stall_word, input int stall_len, input string nm);
        logic [4:0]  eidx;
        logic [31:0] edata;
        int          waitc;
        first_idx  = f;
        last_idx   = l;
        start      = 1'b1;
        dout_ready = 1'b1;
        tick();
        start = 1'b0;
        check({nm, "_read_busy"},  32'(busy),       32'd1);
        check({nm, "_read_valid"}, 32'(dout_valid), 32'd0);
        check({nm, "_read_addr"},  32'(rd_addr),    32'(f));
        for (int k = 0; k < nexp; k++) begin
            eidx  = f + 5'(k);
            edata = regs[eidx];
            waitc = 0;
            while (!dout_valid && waitc < 4) begin
                tick();
                waitc++;
            end
            check({nm, "_lat"},   32'(waitc),      32'd1);
            check({nm, "_valid"}, 32'(dout_valid), 32'd1);
            check({nm, "_idx"},   32'(dout_idx),   32'(eidx));
            check({nm, "_data"},  dout_data,       edata);
            check({nm, "_busy"},  32'(busy),       32'd1);
            if (k == stall_word) begin
                dout_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    regs[eidx] = regs[eidx] ^ 32'hFFFF_0000;
                    tick();
                    check({nm, "_hold_valid"}, 32'(dout_valid), 32'd1);
                    check({nm, "_hold_idx"},   32'(dout_idx),   32'(eidx));
                    check({nm, "_hold_data"},  dout_data,       edata);
                    check({nm, "_hold_done"},  32'(done),       32'd0);
                end
                dout_ready = 1'b1;
            end
            tick();
        end
        check({nm, "_done"},      32'(done),       32'd1);
        check({nm, "_fin_busy"},  32'(busy),       32'd1);
        check({nm, "_fin_valid"}, 32'(dout_valid), 32'd0);
        tick();
        check({nm, "_done_drop"}, 32'(done), 32'd0);
        check({nm, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        first_idx  = 5'd0;
        last_idx   = 5'd0;
        dout_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA5A5_0000 | 32'(i);
        regs[0]  = 32'd0;
        regs[16] = 32'd15;
        regs[17] = 32'd25;
        regs[18] = 32'd666;
        regs[5]  = 32'hABCD_1234;

        tick();
        tick();
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_data",  dout_data,       32'd0);
        check("rst_idx",   32'(dout_idx),   32'd0);
        check("rst_addr",  32'(rd_addr),    32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        rst = 1'b0;
        dout_ready = 1'b1;
        tick();
        check("idle_ready_valid", 32'(dout_valid), 32'd0);
        check("idle_ready_busy",  32'(busy),       32'd0);

        // Three words 16..18 with hand-loaded values 15, 25, 666.
        run_dump(5'd16, 5'd18, 3, -1, 0, "basic");
        // Single word.
        run_dump(5'd5, 5'd5, 1, -1, 0, "single");
        // Wrap 30,31,0,1; $0 reads as the register file supplies it (0).
        run_dump(5'd30, 5'd1, 4, -1, 0, "wrap");
        // Backpressure on the second of three words.
        run_dump(5'd20, 5'd22, 3, 1, 5, "stall");

        // Re-pulsed start during SEND and in FIN must be ignored.
        first_idx = 5'd2;
        last_idx  = 5'd3;
        start     = 1'b1;
        dout_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        check("rep_send_idx", 32'(dout_idx), 32'd2);
        first_idx = 5'd9;
        last_idx  = 5'd9;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("rep_hold_idx",  32'(dout_idx),  32'd2);
        check("rep_hold_data", dout_data,      regs[2]);
        dout_ready = 1'b1;
        tick();
        tick();
        check("rep_second_idx", 32'(dout_idx), 32'd3);
        tick();
        check("rep_done", 32'(done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rep_fin_ignored_busy", 32'(busy), 32'd0);
        check("rep_fin_done_low",     32'(done), 32'd0);
        tick();
        check("rep_no_restart_busy",  32'(busy),       32'd0);
        check("rep_no_restart_valid", 32'(dout_valid), 32'd0);
        check("rep_single_done",      32'(done),       32'd0);

        // Reset while in SEND drops the word, emits no done.
        first_idx = 5'd10;
        last_idx  = 5'd12;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("mid_send_valid", 32'(dout_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(dout_valid), 32'd0);
        check("mid_rst_busy",  32'(busy),       32'd0);
        check("mid_rst_addr",  32'(rd_addr),    32'd0);
        check("mid_rst_done",  32'(done),       32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid_rst_quiet_done", 32'(done), 32'd0);
            check("mid_rst_quiet_busy", 32'(busy), 32'd0);
        end
        run_dump(5'd7, 5'd8, 2, -1, 0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
